// File: rtl/req_arbiter4_pkg.sv
// Shared definitions for the four-requester fixed-priority arbiter:
// one-hot state encoding, requester count and state/grant conversion helpers.
package req_arbiter4_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        GNT0 = 5'b00010,
        GNT1 = 5'b00100,
        GNT2 = 5'b01000,
        GNT3 = 5'b10000
    } state_e;

    // Grant mask owned by a state; IDLE and illegal encodings own nothing.
    function automatic logic [NUM_REQ-1:0] owner_mask(input state_e s);
        owner_mask = {s == GNT3, s == GNT2, s == GNT1, s == GNT0};
    endfunction

    function automatic state_e onehot_to_state(input logic [NUM_REQ-1:0] win);
        case (win)
            4'b0001: onehot_to_state = GNT0;
            4'b0010: onehot_to_state = GNT1;
            4'b0100: onehot_to_state = GNT2;
            4'b1000: onehot_to_state = GNT3;
            default: onehot_to_state = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/req_arbiter4_prio_enc4.sv
// Combinational 4-input fixed-priority encoder; index 0 wins.
// Requests flagged in excl are ignored so the current owner cannot re-win.
module prio_enc4
    import req_arbiter4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] excl,
    output logic [NUM_REQ-1:0] win,
    output logic               valid
);

    logic [NUM_REQ-1:0] cand;

    always_comb begin
        cand  = req & ~excl;
        valid = |cand;
        win   = '0;
        // Scan from lowest priority up so the highest-priority hit is the last write.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win    = '0;
                win[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_arbiter4.sv
// Four-requester fixed-priority arbiter with grant locking.
// The owner keeps its grant until it drops its request; no preemption.
module req_arbiter4
    import req_arbiter4_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_0,
    input  logic req_1,
    input  logic req_2,
    input  logic req_3,
    output logic gnt_0,
    output logic gnt_1,
    output logic gnt_2,
    output logic gnt_3
);

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] excl;
    logic [NUM_REQ-1:0] win;
    logic               win_valid;
    logic [NUM_REQ-1:0] gnt_d, gnt_q;
    state_e             state_d, state_q;

    assign req_vec = {req_3, req_2, req_1, req_0};
    assign excl    = owner_mask(state_q);

    prio_enc4 u_prio_enc4 (
        .req   (req_vec),
        .excl  (excl),
        .win   (win),
        .valid (win_valid)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:
                state_d = win_valid ? onehot_to_state(win) : IDLE;
            GNT0, GNT1, GNT2, GNT3:
                if (|(req_vec & excl)) state_d = state_q;
                else                   state_d = win_valid ? onehot_to_state(win) : IDLE;
            default:
                state_d = IDLE;
        endcase
        // Decoding from the legal next state keeps the grant one-hot even out of a bad encoding.
        gnt_d = owner_mask(state_d);
    end

    always_ff @(posedge clk) begin
        // NOTE: synchronous reset wins over any request and clears a grant mid-ownership.
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    assign {gnt_3, gnt_2, gnt_1, gnt_0} = gnt_q;

endmodule

// File: tb/tb_req_arbiter4.sv
// Directed and random-traffic bench for req_arbiter4; vectors are {req_3..req_0}.
module tb_req_arbiter4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       gnt_0, gnt_1, gnt_2, gnt_3;
    logic [3:0] gnt;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    assign gnt = {gnt_3, gnt_2, gnt_1, gnt_0};

    req_arbiter4 dut (
        .clk   (clk),
        .rst   (rst),
        .req_0 (req[0]),
        .req_1 (req[1]),
        .req_2 (req[2]),
        .req_3 (req[3]),
        .gnt_0 (gnt_0),
        .gnt_1 (gnt_1),
        .gnt_2 (gnt_2),
        .gnt_3 (gnt_3)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [3:0] r, input string tag, input logic [3:0] exp);
        req = r;
        step();
        check(tag, gnt, exp);
    endtask

    initial begin
        logic [3:0] prev_gnt;
        logic [3:0] exp;

        // Reset dominates all-high requests, then gnt_0 wins on release.
        rst = 1'b1;
        apply(4'b1111, "reset_all_req", 4'b0000);
        rst = 1'b0;
        apply(4'b1111, "reset_release", 4'b0001);
        apply(4'b0000, "release_0", 4'b0000);

        // Single requests with gaps.
        apply(4'b0001, "single_0", 4'b0001);
        apply(4'b0000, "gap_0", 4'b0000);
        apply(4'b0000, "gap_0b", 4'b0000);
        apply(4'b0010, "single_1", 4'b0010);
        apply(4'b0000, "gap_1", 4'b0000);
        apply(4'b0100, "single_2", 4'b0100);
        apply(4'b0000, "gap_2", 4'b0000);
        apply(4'b1000, "single_3", 4'b1000);
        apply(4'b1000, "hold_3", 4'b1000);
        apply(4'b1000, "hold_3b", 4'b1000);
        apply(4'b0000, "release_3", 4'b0000);

        // Simultaneous requests and bubble-free hand-off.
        apply(4'b1110, "simul_1", 4'b0010);
        apply(4'b1110, "simul_hold_1", 4'b0010);
        apply(4'b1100, "handoff_2", 4'b0100);
        apply(4'b1000, "handoff_3", 4'b1000);

        // Lock: req_0 arriving must not preempt gnt_3.
        apply(4'b1001, "lock_3", 4'b1000);
        apply(4'b1001, "lock_3b", 4'b1000);
        apply(4'b0001, "handoff_0", 4'b0001);
        apply(4'b0000, "idle_after_0", 4'b0000);

        // Mid-grant reset.
        apply(4'b0100, "pre_rst_2", 4'b0100);
        rst = 1'b1;
        apply(4'b0100, "mid_rst", 4'b0000);
        rst = 1'b0;
        apply(4'b0100, "post_rst_2", 4'b0100);
        apply(4'b0000, "release_2", 4'b0000);

        // A sub-cycle pulse between edges must be ignored.
        #2 req = 4'b0001;
        #2 req = 4'b0000;
        step();
        check("short_pulse", gnt, 4'b0000);

        // Random traffic against a small reference of the lock/priority rules.
        prev_gnt = gnt;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            step();
            if ((prev_gnt & req) != 4'b0000) exp = prev_gnt;
            else                             exp = req & (~req + 4'd1);
            check("rand_model", gnt, exp);
            check("rand_onehot", {3'b000, $onehot0(gnt)}, 4'b0001);
            check("rand_req_backed", gnt & ~req, 4'b0000);
            prev_gnt = gnt;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
